// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and width helpers for the cache page slot
package cache_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_LOADING  = 2'd1,
        ST_LOADED   = 2'd2,
        ST_FLUSHING = 2'd3
    } page_state_t;

    function automatic int tag_bits(input int address_size, input int word_bits);
        return address_size - word_bits - 2;
    endfunction

    function automatic int slot_address_bits(input int index_bits, input int word_bits);
        return index_bits + word_bits + 2;
    endfunction

endpackage

// File: rtl/cache_page_if.sv
// rtl/cache_page_if.sv - bus-side and memory-side signal bundle of one cache page slot
interface cache_page_if
    import cache_pkg::*;
#(
    parameter int ADDRESS_SIZE = 24,
    parameter int WORD_BITS    = 5,
    parameter int INDEX_BITS   = 4
);
    localparam int SLOT_BITS = slot_address_bits(INDEX_BITS, WORD_BITS);

    logic                    bus_enable;
    logic                    bus_write;
    logic [ADDRESS_SIZE-1:0] bus_address;
    logic                    page_selected;
    logic                    page_valid;
    logic                    word_ready;
    logic [SLOT_BITS-1:0]    bus_sram_address;

    logic [SLOT_BITS-1:0]    sram_address;
    logic                    sram_busy;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDRESS_SIZE-1:0] mem_address;
    logic                    mem_ack;

    modport master (
        output bus_enable, bus_write, bus_address, page_selected, sram_busy, mem_ack,
        input  page_valid, word_ready, bus_sram_address, sram_address,
               mem_read, mem_write, mem_address
    );

    modport slave (
        input  bus_enable, bus_write, bus_address, page_selected, sram_busy, mem_ack,
        output page_valid, word_ready, bus_sram_address, sram_address,
               mem_read, mem_write, mem_address
    );

endinterface

// File: rtl/cache_word_scan.sv
// rtl/cache_word_scan.sv - wrapping word pointer shared by the fill and flush sweeps
module cache_word_scan #(
    parameter int WORD_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WORD_BITS-1:0] load_word,
    input  logic                 step,
    output logic [WORD_BITS-1:0] pointer,
    output logic                 done
);
    // count tracks steps since load, so a sweep ends after one full lap whatever the start word
    logic [WORD_BITS-1:0] count;

    assign done = step && (count == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pointer <= '0;
            count   <= '0;
        end else if (load) begin
            pointer <= load_word;
            count   <= '0;
        end else if (step) begin
            pointer <= pointer + 1'b1;
            count   <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_page.sv
// rtl/cache_page.sv - one page slot of a paged cache: critical-word-first fill, dirty write-back
module cache_page
    import cache_pkg::*;
#(
    parameter int ADDRESS_SIZE = 24,
    parameter int WORD_BITS    = 5,
    parameter int INDEX_BITS   = 4,
    parameter int INDEX        = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic auto_paging,
    input  logic auto_paging_changed,
    input  logic manual_set,
    input  logic [tag_bits(ADDRESS_SIZE, WORD_BITS)-INDEX_BITS-1:0] manual_page,
    input  logic invalidate,
    input  logic write_back_en,
    output logic dirty,
    cache_page_if.slave bus
);
    localparam int TAG_BITS = tag_bits(ADDRESS_SIZE, WORD_BITS);
    localparam int WORDS    = 1 << WORD_BITS;
    localparam logic [INDEX_BITS-1:0] SLOT = INDEX[INDEX_BITS-1:0];

    page_state_t          state;
    logic [TAG_BITS-1:0]  tag;
    logic [TAG_BITS-1:0]  pend_tag;
    logic [WORD_BITS-1:0] pend_start;
    logic                 pending;
    logic                 ack_pending;
    logic                 mem_read_q;
    logic [WORDS-1:0]     valid_bits;
    logic [WORDS-1:0]     dirty_bits;

    logic                 aligned;
    logic [WORD_BITS-1:0] w;
    logic [TAG_BITS-1:0]  bus_tag;
    logic [TAG_BITS-1:0]  new_tag;
    logic [WORD_BITS-1:0] new_start;
    logic                 tag_match;
    logic                 auto_miss;
    logic                 manual_change;
    logic                 change;
    logic                 kill;
    logic                 flush_ok;
    logic                 transferring;
    logic                 complete;
    logic                 step;
    logic                 start_fill;
    logic                 start_flush;
    logic                 resume_fill;
    logic                 scan_load;
    logic [WORD_BITS-1:0] scan_load_word;
    logic [WORD_BITS-1:0] ptr;
    logic                 scan_done;

    assign aligned   = bus.bus_enable && (bus.bus_address[1:0] == 2'b00);
    assign w         = bus.bus_address[WORD_BITS+1:2];
    assign bus_tag   = bus.bus_address[ADDRESS_SIZE-1:WORD_BITS+2];
    // in manual mode the slot only owns addresses whose low tag bits equal its index
    assign tag_match = auto_paging ? (tag == bus_tag)
                                   : (tag[INDEX_BITS-1:0] == bus_tag[INDEX_BITS-1:0]);

    assign bus.page_valid = ((state == ST_LOADING) || (state == ST_LOADED)) && tag_match;
    assign bus.word_ready = bus.page_valid && bus.page_selected && valid_bits[w]
                            && (state != ST_FLUSHING);

    assign auto_miss     = aligned && bus.page_selected && auto_paging && !bus.page_valid;
    assign manual_change = !auto_paging && manual_set;
    assign change        = auto_miss || manual_change;
    assign new_tag       = manual_change ? {manual_page, SLOT} : bus_tag;
    assign new_start     = manual_change ? '0 : w;
    assign kill          = invalidate || auto_paging_changed;
    assign dirty         = |dirty_bits;
    assign flush_ok      = dirty && write_back_en;

    // an ack seen while the SRAM port is busy is held until the port frees up
    assign transferring = (state == ST_LOADING) || ((state == ST_FLUSHING) && dirty_bits[ptr]);
    assign complete     = transferring && !bus.sram_busy && (bus.mem_ack || ack_pending);
    assign step         = ((state == ST_LOADING) && complete)
                       || ((state == ST_FLUSHING) && (!dirty_bits[ptr] || complete));

    assign start_fill     = !kill && change
                            && ((state == ST_EMPTY) || ((state == ST_LOADED) && !flush_ok));
    assign start_flush    = (state == ST_LOADED) && flush_ok && (kill || change);
    assign resume_fill    = (state == ST_FLUSHING) && scan_done && pending;
    assign scan_load      = start_fill || start_flush || resume_fill;
    assign scan_load_word = start_fill ? new_start : (resume_fill ? pend_start : '0);

    cache_word_scan #(
        .WORD_BITS (WORD_BITS)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .load      (scan_load),
        .load_word (scan_load_word),
        .step      (step),
        .pointer   (ptr),
        .done      (scan_done)
    );

    assign bus.mem_read         = mem_read_q;
    assign bus.mem_write        = (state == ST_FLUSHING) && dirty_bits[ptr];
    assign bus.mem_address      = {tag, ptr, 2'b00};
    assign bus.sram_address     = {SLOT, ptr, 2'b00};
    assign bus.bus_sram_address = {SLOT, w, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_EMPTY;
            tag         <= '0;
            pend_tag    <= '0;
            pend_start  <= '0;
            pending     <= 1'b0;
            ack_pending <= 1'b0;
            mem_read_q  <= 1'b0;
            valid_bits  <= '0;
            dirty_bits  <= '0;
        end else begin
            if (complete)
                ack_pending <= 1'b0;
            else if (transferring && bus.mem_ack && bus.sram_busy)
                ack_pending <= 1'b1;

            if (aligned && bus.bus_write && bus.word_ready)
                dirty_bits[w] <= 1'b1;

            case (state)
                ST_EMPTY: begin
                    if (start_fill) begin
                        tag        <= new_tag;
                        valid_bits <= '0;
                        dirty_bits <= '0;
                        mem_read_q <= 1'b1;
                        state      <= ST_LOADING;
                    end
                end
                ST_LOADING: begin
                    if (kill) begin
                        mem_read_q  <= 1'b0;
                        ack_pending <= 1'b0;
                        state       <= ST_EMPTY;
                    end else if (complete) begin
                        valid_bits[ptr] <= 1'b1;
                        if (scan_done) begin
                            mem_read_q <= 1'b0;
                            state      <= ST_LOADED;
                        end
                    end
                end
                ST_LOADED: begin
                    if (start_flush) begin
                        pending    <= !kill;
                        pend_tag   <= new_tag;
                        pend_start <= new_start;
                        state      <= ST_FLUSHING;
                    end else if (kill) begin
                        state <= ST_EMPTY;
                    end else if (start_fill) begin
                        tag        <= new_tag;
                        valid_bits <= '0;
                        dirty_bits <= '0;
                        mem_read_q <= 1'b1;
                        state      <= ST_LOADING;
                    end
                end
                ST_FLUSHING: begin
                    if (complete)
                        dirty_bits[ptr] <= 1'b0;
                    if (scan_done) begin
                        if (pending) begin
                            tag        <= pend_tag;
                            valid_bits <= '0;
                            dirty_bits <= '0;
                            pending    <= 1'b0;
                            mem_read_q <= 1'b1;
                            state      <= ST_LOADING;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_page.sv
// tb/tb_cache_page.sv - directed self-checking bench for cache_page with slot index 3
module tb_cache_page;
    localparam int AS  = 24;
    localparam int WB  = 5;
    localparam int IB  = 4;
    localparam int IDX = 3;
    localparam int TB  = AS - WB - 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic auto_paging, auto_paging_changed, manual_set, invalidate, write_back_en, dirty;
    logic [TB-IB-1:0] manual_page;

    int total = 0;
    int bad   = 0;

    cache_page_if #(.ADDRESS_SIZE(AS), .WORD_BITS(WB), .INDEX_BITS(IB)) bus ();

    cache_page #(
        .ADDRESS_SIZE (AS),
        .WORD_BITS    (WB),
        .INDEX_BITS   (IB),
        .INDEX        (IDX)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .auto_paging         (auto_paging),
        .auto_paging_changed (auto_paging_changed),
        .manual_set          (manual_set),
        .manual_page         (manual_page),
        .invalidate          (invalidate),
        .write_back_en       (write_back_en),
        .dirty               (dirty),
        .bus                 (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        logic        sel;
        logic        auto_mode;
        logic        exp_valid;
        logic        exp_ready;
        logic [10:0] exp_bsa;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          nwr;
        logic [23:0] wa0, wa1;
        logic        reloaded, wr_seen;

        vecs[0] = '{24'h000180, 1'b1, 1'b0, 1'b1, 1'b1, 11'h180};
        vecs[1] = '{24'h000184, 1'b1, 1'b0, 1'b1, 1'b0, 11'h184};
        vecs[2] = '{24'h000180, 1'b0, 1'b0, 1'b1, 1'b0, 11'h180};
        vecs[3] = '{24'h000200, 1'b1, 1'b0, 1'b0, 1'b0, 11'h180};
        vecs[4] = '{24'h0D2980, 1'b1, 1'b1, 1'b1, 1'b1, 11'h180};
        vecs[5] = '{24'h000180, 1'b1, 1'b1, 1'b0, 1'b0, 11'h180};
        vecs[6] = '{24'hFFF980, 1'b1, 1'b0, 1'b1, 1'b1, 11'h180};
        vecs[7] = '{24'h0D29FC, 1'b1, 1'b1, 1'b1, 1'b0, 11'h1FC};

        auto_paging = 1'b1; auto_paging_changed = 1'b0; manual_set = 1'b0;
        manual_page = '0; invalidate = 1'b0; write_back_en = 1'b0;
        bus.bus_enable = 1'b0; bus.bus_write = 1'b0; bus.bus_address = '0;
        bus.page_selected = 1'b1; bus.sram_busy = 1'b0; bus.mem_ack = 1'b0;

        tick(); tick();
        chk("rst_page_valid", 32'(bus.page_valid), 0);
        chk("rst_word_ready", 32'(bus.word_ready), 0);
        chk("rst_dirty", 32'(dirty), 0);
        chk("rst_mem_read", 32'(bus.mem_read), 0);
        chk("rst_mem_write", 32'(bus.mem_write), 0);
        chk("rst_sram_address", 32'(bus.sram_address), 32'h180);
        chk("rst_bus_sram_address", 32'(bus.bus_sram_address), 32'h180);
        chk("rst_mem_address", 32'(bus.mem_address), 0);
        @(negedge clk) rst = 1'b1;

        // auto miss, critical word first
        bus.bus_enable = 1'b1; bus.bus_address = 24'h001234;
        tick();
        chk("fill_mem_read", 32'(bus.mem_read), 1);
        chk("fill_first_addr", 32'(bus.mem_address), 32'h001234);
        chk("ready_before_ack", 32'(bus.word_ready), 0);
        bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
        chk("ready_after_ack", 32'(bus.word_ready), 1);
        chk("fill_second_addr", 32'(bus.mem_address), 32'h001238);
        bus.mem_ack = 1'b1;
        repeat (30) tick();
        chk("read_before_last_ack", 32'(bus.mem_read), 1);
        tick(); bus.mem_ack = 1'b0;
        chk("loaded_read_low", 32'(bus.mem_read), 0);
        chk("loaded_page_valid", 32'(bus.page_valid), 1);

        // dirty words 2 and 7, then miss with write-back
        bus.bus_write = 1'b1; bus.bus_address = 24'h001208; tick();
        bus.bus_address = 24'h00121C; tick();
        bus.bus_write = 1'b0;
        chk("dirty_after_writes", 32'(dirty), 1);
        write_back_en = 1'b1; bus.bus_address = 24'h004000;
        tick();
        nwr = 0; wa0 = '0; wa1 = '0; reloaded = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.mem_read) begin
                reloaded = 1'b1;
                break;
            end
            if (bus.mem_write) begin
                if (nwr == 0) wa0 = bus.mem_address;
                else if (nwr == 1) wa1 = bus.mem_address;
                nwr++;
            end
            bus.mem_ack = bus.mem_write;
            tick();
        end
        bus.mem_ack = 1'b0;
        chk("flush_reload_reached", 32'(reloaded), 1);
        chk("flush_write_count", 32'(nwr), 2);
        chk("flush_write_addr0", 32'(wa0), 32'h001208);
        chk("flush_write_addr1", 32'(wa1), 32'h00121C);
        chk("reload_addr", 32'(bus.mem_address), 32'h004000);
        chk("flush_dirty_cleared", 32'(dirty), 0);
        chk("reload_no_write", 32'(bus.mem_write), 0);

        // ack while the SRAM port is busy
        chk("reload_word0_not_ready", 32'(bus.word_ready), 0);
        bus.mem_ack = 1'b1; bus.sram_busy = 1'b1; tick(); bus.mem_ack = 1'b0;
        chk("busy_hold_1", 32'(bus.mem_address), 32'h004000);
        tick(); tick();
        chk("busy_hold_3", 32'(bus.mem_address), 32'h004000);
        bus.sram_busy = 1'b0; tick();
        chk("busy_release_advance", 32'(bus.mem_address), 32'h004004);
        chk("busy_release_ready", 32'(bus.word_ready), 1);
        tick();
        chk("busy_single_advance", 32'(bus.mem_address), 32'h004004);

        // invalidate mid-fill
        bus.mem_ack = 1'b1; repeat (9) tick(); bus.mem_ack = 1'b0;
        chk("fill_word10_addr", 32'(bus.mem_address), 32'h004028);
        bus.bus_enable = 1'b0; invalidate = 1'b1; tick(); invalidate = 1'b0;
        chk("inv_page_valid", 32'(bus.page_valid), 0);
        chk("inv_mem_read", 32'(bus.mem_read), 0);
        wr_seen = 1'b0;
        repeat (4) begin
            tick();
            if (bus.mem_write) wr_seen = 1'b1;
        end
        chk("inv_no_write", 32'(wr_seen), 0);
        chk("inv_stays_empty", 32'(bus.mem_read), 0);

        // reset in the middle of a flush
        bus.bus_enable = 1'b1; bus.bus_address = 24'h001234; tick();
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!bus.mem_read) break;
            tick();
        end
        bus.mem_ack = 1'b0;
        chk("refill_done", 32'(bus.mem_read), 0);
        bus.bus_write = 1'b1; bus.bus_address = 24'h001214; tick();
        bus.bus_write = 1'b0; bus.bus_enable = 1'b0;
        invalidate = 1'b1; tick(); invalidate = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.mem_write) break;
            tick();
        end
        chk("flush_word5_write", 32'(bus.mem_write), 1);
        chk("flush_word5_addr", 32'(bus.mem_address), 32'h001214);
        #2 rst = 1'b0;
        #1;
        chk("rst_flush_mem_write", 32'(bus.mem_write), 0);
        chk("rst_flush_dirty", 32'(dirty), 0);
        chk("rst_flush_page_valid", 32'(bus.page_valid), 0);
        chk("rst_flush_mem_read", 32'(bus.mem_read), 0);
        @(negedge clk) rst = 1'b1;
        tick();
        chk("post_reset_idle", 32'(bus.mem_write), 0);

        // manual page
        auto_paging = 1'b0; manual_page = 13'h1A5; manual_set = 1'b1; tick(); manual_set = 1'b0;
        chk("manual_mem_read", 32'(bus.mem_read), 1);
        chk("manual_first_addr", 32'(bus.mem_address), 32'h0D2980);
        chk("manual_sram_address", 32'(bus.sram_address), 32'h180);
        bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
        chk("manual_second_addr", 32'(bus.mem_address), 32'h0D2984);

        for (int i = 0; i < 8; i++) begin
            bus.bus_address   = vecs[i].addr;
            bus.page_selected = vecs[i].sel;
            auto_paging       = vecs[i].auto_mode;
            #1;
            chk($sformatf("vec%0d_page_valid", i), 32'(bus.page_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_word_ready", i), 32'(bus.word_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_bus_sram", i), 32'(bus.bus_sram_address), 32'(vecs[i].exp_bsa));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
